seq_event_counter: RTL and testbench
====================================

SEQ_EVENT_COUNTER -- requirements
Module: seq_event_counter

Interface
REQ-001 Parameter WIDTH, default 22, SHALL set the bit width of each channel count.
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent counters (range 1..16).
REQ-003 Parameter SATURATE, default 0, SHALL select the overflow mode: 0 wraps, 1 holds at all-ones.
REQ-004 Port clk, input, 1: clock; all state SHALL update on its rising edge only.
REQ-005 Port reset, input, 1: reset, synchronous, active-high.
REQ-006 Port inc, input, CHANNELS: per-channel count enable, sampled each edge.
REQ-007 Port clr, input, CHANNELS: per-channel synchronous clear.
REQ-008 Port limit, input, WIDTH: terminal-count compare value, common to all channels.
REQ-009 Port count, output, CHANNELS*WIDTH: live counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-010 Port ovf, output, CHANNELS: sticky per-channel overflow flags.
REQ-011 Port tc, output, CHANNELS: one-cycle terminal-count pulses.
REQ-012 Port snap_req, input, 1: request to capture all counts for readout.
REQ-013 Port snap_busy, output, 1: high while a readout is in progress.
REQ-014 Port rd_valid, output, 1, and port rd_ready, input, 1: readout handshake.
REQ-015 Port rd_data, output, WIDTH; port rd_chan, output, clog2(CHANNELS) (min 1); port rd_last, output, 1: readout payload.

Function
REQ-016 Per channel, each edge: clr[i]=1 SHALL set count to 0 and ovf[i] to 0, overriding inc[i] (result 0, not 1).
REQ-017 When clr[i]=0 and inc[i]=1, count[i] SHALL increment by 1; when inc[i]=0, count[i] SHALL hold.
REQ-018 In wrap mode, an increment from all-ones SHALL give 0 and set ovf[i]=1.
REQ-019 In saturate mode, an increment at all-ones SHALL hold all-ones and set ovf[i]=1.
REQ-020 ovf[i] SHALL stay set until clr[i] or reset.
REQ-021 tc[i] SHALL be 1 for exactly the one cycle after an edge at which an increment made count[i] equal to limit.
REQ-022 tc[i] SHALL NOT assert on clear or hold, including when limit=0 and clr occurs; a saturated hold at limit SHALL NOT re-pulse.
REQ-023 Readout FSM states SHALL be IDLE and SEND.
REQ-024 IDLE with snap_req=1: at that edge, pre-update values of all counts SHALL be latched into a shadow bank, rd_chan set to 0, and the FSM SHALL enter SEND.
REQ-025 In SEND: rd_valid=1, rd_data = shadow[rd_chan], rd_last = (rd_chan == CHANNELS-1), snap_busy=1.
REQ-026 rd_data, rd_chan and rd_last SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-027 On rd_valid & rd_ready with rd_last=0, rd_chan SHALL advance by 1.
REQ-028 On rd_valid & rd_ready with rd_last=1, the FSM SHALL return to IDLE with rd_valid=0 on the next cycle.
REQ-029 snap_req in SEND SHALL be ignored and not queued; a new capture requires snap_req in IDLE.
REQ-030 Live counting, clear, ovf and tc SHALL continue unaffected during SEND; the shadow bank SHALL NOT change in SEND.
REQ-031 With CHANNELS=1, a single handshake SHALL complete a readout, with rd_last=1 throughout SEND.

Reset
REQ-032 reset=1 SHALL set count, ovf, tc, rd_data and rd_chan to 0, rd_valid, rd_last and snap_busy to 0, and the FSM to IDLE, overriding all other inputs.
REQ-033 reset during SEND SHALL abort the readout with no further handshake.

Verification
REQ-034 WIDTH=4, wrap mode, inc[0] held for 17 cycles -> count0 sequence 0..15, 0, 1; ovf[0] rises when count0 reaches 0; tc[0] pulses once when limit=5 and count0 reaches 5.
REQ-035 WIDTH=4, SATURATE=1, inc[1] held for 20 cycles -> count1 stops at 15, ovf[1]=1; then clr[1]&inc[1] in the same cycle -> count1=0 and ovf[1]=0.
REQ-036 Counts 3/7/9/1, snap_req pulse, rd_ready=1 -> 4 beats: rd_data 3, 7, 9, 1; rd_chan 0..3; rd_last on beat 4; snap_busy low after.
REQ-037 rd_ready toggled randomly while inc is active throughout -> payload stable under stall; data equals capture-time values; second snap_req in SEND ignored.
REQ-038 reset asserted mid-SEND on beat 2 -> next cycle rd_valid=0, state IDLE, all counts 0.

Source files
------------

// File: rtl/seq_event_counter_if.sv
// Readout handshake bundle for seq_event_counter.
// master: counter side (snap_busy, rd_valid, rd_data, rd_chan, rd_last out;
//         snap_req, rd_ready in). slave: consumer side, the reverse.
interface seq_event_counter_if #(
    parameter int WIDTH    = 22,
    parameter int CHANNELS = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             snap_req;
    logic             snap_busy;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    rd_chan;
    logic             rd_last;

    modport master (
        input  snap_req,
        input  rd_ready,
        output snap_busy,
        output rd_valid,
        output rd_data,
        output rd_chan,
        output rd_last
    );

    modport slave (
        output snap_req,
        output rd_ready,
        input  snap_busy,
        input  rd_valid,
        input  rd_data,
        input  rd_chan,
        input  rd_last
    );
endinterface

// File: rtl/seq_event_counter.sv
// Multi-channel event counter with sticky overflow, terminal-count pulses
// and a snapshot readout streamed one channel per valid/ready beat.
// Ports: clk, reset (sync, active-high), inc/clr per channel, limit,
//        count (packed per channel), ovf, tc, rd (readout interface).
module seq_event_counter #(
    parameter int WIDTH    = 22,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [WIDTH-1:0]          limit,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS-1:0]       tc,
    seq_event_counter_if.master       rd
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0]    LAST = CW'(CHANNELS - 1);
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_count  [CHANNELS];
    logic [WIDTH-1:0]    r_shadow [CHANNELS];
    logic [CHANNELS-1:0] r_ovf;
    logic [CHANNELS-1:0] r_tc;
    logic [CW-1:0]       r_chan;
    logic [WIDTH-1:0]    r_data;
    logic                r_valid;
    logic                r_last;
    logic [CW-1:0]       w_next_chan;

    assign w_next_chan = r_chan + 1'b1;

    // Live counters. tc only fires when an increment lands on limit,
    // so a saturated hold at all-ones never re-pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_count[i] <= '0;
            end
            r_ovf <= '0;
            r_tc  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_tc[i] <= 1'b0;
                if (clr[i]) begin
                    r_count[i] <= '0;
                    r_ovf[i]   <= 1'b0;
                end else if (inc[i]) begin
                    if (r_count[i] == ONES) begin
                        r_ovf[i] <= 1'b1;
                        if (SATURATE == 0) begin
                            r_count[i] <= '0;
                            r_tc[i]    <= (limit == '0);
                        end
                    end else begin
                        r_count[i] <= r_count[i] + 1'b1;
                        r_tc[i]    <= (WIDTH'(r_count[i] + 1'b1) == limit);
                    end
                end
            end
        end
    end

    // Readout FSM. The shadow bank takes the pre-update counts at the
    // capture edge; rd_data is kept registered as shadow[rd_chan].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_chan  <= '0;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (rd.snap_req) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_shadow[i] <= r_count[i];
                        end
                        r_chan  <= '0;
                        r_data  <= r_count[0];
                        r_last  <= (CHANNELS == 1);
                        r_valid <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (rd.rd_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_chan <= w_next_chan;
                            r_data <= r_shadow[w_next_chan];
                            r_last <= (w_next_chan == LAST);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign count[g*WIDTH +: WIDTH] = r_count[g];
    end

    assign ovf          = r_ovf;
    assign tc           = r_tc;
    assign rd.rd_valid  = r_valid;
    assign rd.snap_busy = r_valid;
    assign rd.rd_data   = r_data;
    assign rd.rd_chan   = r_chan;
    assign rd.rd_last   = r_last;
endmodule

// File: tb/tb_seq_event_counter.sv
// Bench for seq_event_counter: wrap and saturate instances, WIDTH=4,
// CHANNELS=4, reference model plus readout scoreboard queue.
module tb_seq_event_counter;
    logic        clk;
    logic        reset;
    logic [3:0]  inc;
    logic [3:0]  clr;
    logic [3:0]  limit;
    logic [15:0] cnt_w;
    logic [15:0] cnt_s;
    logic [3:0]  ovf_w;
    logic [3:0]  ovf_s;
    logic [3:0]  tc_w;
    logic [3:0]  tc_s;

    seq_event_counter_if #(.WIDTH(4), .CHANNELS(4)) rif ();
    seq_event_counter_if #(.WIDTH(4), .CHANNELS(4)) sif ();

    seq_event_counter #(.WIDTH(4), .CHANNELS(4), .SATURATE(0)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .clr   (clr),
        .limit (limit),
        .count (cnt_w),
        .ovf   (ovf_w),
        .tc    (tc_w),
        .rd    (rif.master)
    );

    seq_event_counter #(.WIDTH(4), .CHANNELS(4), .SATURATE(1)) u_sat (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .clr   (clr),
        .limit (limit),
        .count (cnt_s),
        .ovf   (ovf_s),
        .tc    (tc_s),
        .rd    (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int beats  = 0;
    int m_cnt [2][4];
    bit m_ovf [2][4];
    bit m_tc  [2][4];
    bit m_send;
    int m_chan;
    int exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic tick();
        bit         fire;
        bit         stalled;
        logic [3:0] h_data;
        logic [1:0] h_chan;
        logic       h_last;
        logic [3:0] c;
        fire = m_send && rif.rd_ready && !reset;
        if (fire) begin
            if (exp_q.size() == 0) chk("rd_extra_beat", 1, 0);
            else chk("rd_data", rif.rd_data, exp_q.pop_front());
            chk("rd_chan_beat", rif.rd_chan, m_chan);
            chk("rd_last_beat", rif.rd_last, m_chan == 3);
            beats++;
        end
        stalled = m_send && !rif.rd_ready && !reset;
        h_data  = rif.rd_data;
        h_chan  = rif.rd_chan;
        h_last  = rif.rd_last;
        @(posedge clk);
        if (reset) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 4; i++) begin
                    m_cnt[d][i] = 0;
                    m_ovf[d][i] = 0;
                    m_tc[d][i]  = 0;
                end
            m_send = 0;
            m_chan = 0;
            exp_q.delete();
        end else begin
            if (!m_send && rif.snap_req) begin
                for (int i = 0; i < 4; i++) exp_q.push_back(m_cnt[0][i]);
                m_send = 1;
                m_chan = 0;
            end else if (fire) begin
                if (m_chan == 3) m_send = 0;
                else m_chan++;
            end
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 4; i++) begin
                    m_tc[d][i] = 0;
                    if (clr[i]) begin
                        m_cnt[d][i] = 0;
                        m_ovf[d][i] = 0;
                    end else if (inc[i]) begin
                        if (m_cnt[d][i] == 15) begin
                            m_ovf[d][i] = 1;
                            if (d == 0) begin
                                m_cnt[d][i] = 0;
                                m_tc[d][i]  = (limit == 0);
                            end
                        end else begin
                            m_cnt[d][i]++;
                            m_tc[d][i] = (m_cnt[d][i] == limit);
                        end
                    end
                end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            c = cnt_w[i*4 +: 4];
            chk($sformatf("cnt%0d_wrap", i), c, m_cnt[0][i]);
            c = cnt_s[i*4 +: 4];
            chk($sformatf("cnt%0d_sat", i), c, m_cnt[1][i]);
            chk($sformatf("ovf%0d_wrap", i), ovf_w[i], m_ovf[0][i]);
            chk($sformatf("ovf%0d_sat", i), ovf_s[i], m_ovf[1][i]);
            chk($sformatf("tc%0d_wrap", i), tc_w[i], m_tc[0][i]);
            chk($sformatf("tc%0d_sat", i), tc_s[i], m_tc[1][i]);
        end
        chk("rd_valid", rif.rd_valid, m_send);
        chk("snap_busy", rif.snap_busy, m_send);
        if (m_send) begin
            chk("rd_chan", rif.rd_chan, m_chan);
            chk("rd_last", rif.rd_last, m_chan == 3);
        end
        if (reset) begin
            chk("rst_rd_data", rif.rd_data, 0);
            chk("rst_rd_chan", rif.rd_chan, 0);
            chk("rst_rd_last", rif.rd_last, 0);
        end
        if (stalled && m_send) begin
            chk("stall_data", rif.rd_data, h_data);
            chk("stall_chan", rif.rd_chan, h_chan);
            chk("stall_last", rif.rd_last, h_last);
        end
    endtask

    int tcn;
    int tgt [4] = '{3, 7, 9, 1};

    initial begin
        reset = 1;
        inc   = '0;
        clr   = '0;
        limit = '0;
        rif.snap_req = 0;
        rif.rd_ready = 0;
        sif.snap_req = 0;
        sif.rd_ready = 0;
        m_send = 0;
        m_chan = 0;
        tick();
        tick();
        reset = 0;

        // wrap through all-ones with limit 5
        limit = 4'd5;
        inc   = 4'b0001;
        tcn   = 0;
        for (int k = 0; k < 17; k++) begin
            tick();
            if (tc_w[0]) tcn++;
        end
        chk("tc0_pulses", tcn, 1);
        chk("cnt0_after17", cnt_w[3:0], 1);

        // saturate, then clear wins over inc
        inc = 4'b0010;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_cnt1", cnt_s[7:4], 15);
        chk("sat_ovf1", ovf_s[1], 1);
        clr = 4'b0010;
        tick();
        clr = 4'b0000;
        inc = 4'b0000;
        tick();

        // clear everything with limit 0: no tc
        limit = 4'd0;
        clr   = 4'b1111;
        tick();
        tick();
        clr = 4'b0000;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 4; i++) inc[i] = (k < tgt[i]);
            tick();
        end
        inc = '0;

        // snapshot 3/7/9/1 with ready held
        beats = 0;
        rif.rd_ready = 1;
        rif.snap_req = 1;
        tick();
        rif.snap_req = 0;
        for (int k = 0; k < 6; k++) tick();
        chk("beats_3791", beats, 4);
        chk("q_empty_3791", exp_q.size(), 0);

        // random stall with live counting and a re-request in SEND
        limit = 4'd5;
        beats = 0;
        rif.snap_req = 1;
        tick();
        for (int k = 0; k < 40; k++) begin
            inc = 4'($urandom);
            clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
            rif.rd_ready = 1'($urandom);
            rif.snap_req = (k == 3 || k == 5);
            tick();
        end
        rif.snap_req = 0;
        rif.rd_ready = 1;
        inc = '0;
        clr = '0;
        for (int k = 0; k < 8; k++) tick();
        chk("q_empty_rand", exp_q.size(), 0);
        chk("idle_rand", rif.rd_valid, 0);

        // reset on beat 2
        inc = 4'b1111;
        tick();
        tick();
        rif.snap_req = 1;
        tick();
        rif.snap_req = 0;
        tick();
        rif.rd_ready = 0;
        chk("beat2_chan", rif.rd_chan, 1);
        reset = 1;
        tick();
        reset = 0;
        inc = '0;
        chk("rst_valid", rif.rd_valid, 0);
        chk("rst_cnt_all", cnt_w, 0);
        rif.rd_ready = 1;
        for (int k = 0; k < 3; k++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
